// File: rtl/video_pixel_fetch_if.sv
// Framebuffer read bus between the pixel fetcher (master) and the memory arbiter (slave).
// A request is held with a stable address until the slave pulses mem_ack with mem_rdata valid.
interface video_pixel_fetch_if;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/video_pixel_fetch.sv
// Line-doubled 320x240 4bpp framebuffer scan-out for 640x480: ping-pong row prefetch into two
// line buffers, then a two-stage pixel path through a 16-entry RGB444 palette.
module video_pixel_fetch #(
  parameter int FB_WORDS = 80,
  parameter int SRC_ROWS = 240
) (
  input  logic                       clk_pix,
  input  logic                       rst,
  input  logic [9:0]                 sx,
  input  logic [9:0]                 sy,
  input  logic                       de,
  input  logic                       hsync,
  input  logic                       vsync,
  input  logic [19:0]                fb_base,
  video_pixel_fetch_if.master        mem,
  input  logic                       pal_we,
  input  logic [3:0]                 pal_addr,
  input  logic [11:0]                pal_data,
  output logic [11:0]                rgb,
  output logic                       de_o,
  output logic                       hsync_o,
  output logic                       vsync_o,
  output logic                       underrun
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [19:0]        row_addr;
  logic               tgt;
  logic [1:0]         valid;
  logic               trig;
  logic [9:0]         trig_row;
  logic [19:0]        trig_addr;
  logic               last;
  logic [DATA_W-1:0]  lbuf [2][FB_WORDS];
  logic [11:0]        pal  [16];

  logic [DATA_W-1:0]  word_p1;
  logic [1:0]         nib_p1;
  logic               vld_p1, bvalid_p1, hs_p1, vs_p1;

  function automatic logic [3:0] sel_nib(input logic [DATA_W-1:0] w, input logic [1:0] n);
    case (n)
      2'd0:    sel_nib = w[15:12];
      2'd1:    sel_nib = w[11:8];
      2'd2:    sel_nib = w[7:4];
      default: sel_nib = w[3:0];
    endcase
  endfunction

  // Row 0 is prefetched in the last blanking line; row k+1 is fetched while row k shows its first line.
  always_comb begin
    trig     = 1'b0;
    trig_row = '0;
    if (sx == 10'd0) begin
      if (sy == 10'd523) begin
        trig = 1'b1;
      end else if (!sy[0] && (int'({1'b0, sy[9:1]}) + 1 < SRC_ROWS)) begin
        trig     = 1'b1;
        trig_row = {1'b0, sy[9:1]} + 10'd1;
      end
    end
  end

  assign trig_addr    = fb_base + 20'(trig_row) * 20'(FB_WORDS);
  assign last         = (cnt == CNT_W'(FB_WORDS - 1));
  assign mem.mem_addr = row_addr + 20'(cnt);

  always_comb begin
    state_nxt   = state;
    mem.mem_req = 1'b0;
    case (state)
      IDLE: if (trig) state_nxt = REQ;
      REQ: begin
        mem.mem_req = 1'b1;
        if (!trig && mem.mem_ack && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A new trigger always wins over an in-flight ack: the old fetch is abandoned outright.
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      row_addr <= '0;
      tgt      <= 1'b0;
      valid    <= 2'b00;
      underrun <= 1'b0;
    end else begin
      state <= state_nxt;
      if (trig) begin
        row_addr           <= trig_addr;
        cnt                <= '0;
        tgt                <= trig_row[0];
        valid[trig_row[0]] <= 1'b0;
        if (state == REQ) underrun <= 1'b1;
      end else if (state == REQ && mem.mem_ack) begin
        cnt <= cnt + 1'b1;
        if (last) valid[tgt] <= 1'b1;
      end
      if (de && !valid[sy[1]]) underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (state == REQ && mem.mem_ack && !trig) lbuf[tgt][cnt] <= mem.mem_rdata;
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) pal[i] <= '0;
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  // Stage 1: line-buffer word fetch and nibble select
  always_ff @(posedge clk_pix) begin
    if (de) begin
      word_p1 <= lbuf[sy[1]][sx[9:3]];
      nib_p1  <= sx[2:1];
    end
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      bvalid_p1 <= 1'b0;
      hs_p1     <= 1'b1;
      vs_p1     <= 1'b1;
    end else begin
      vld_p1    <= de;
      bvalid_p1 <= valid[sy[1]];
      hs_p1     <= hsync;
      vs_p1     <= vsync;
    end
  end

  // Stage 2: palette lookup; a same-edge palette write is seen only by later reads
  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      rgb     <= '0;
      de_o    <= 1'b0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else begin
      rgb     <= (vld_p1 && bvalid_p1) ? pal[sel_nib(word_p1, nib_p1)] : 12'h000;
      de_o    <= vld_p1;
      hsync_o <= hs_p1;
      vsync_o <= vs_p1;
    end
  end

endmodule

// File: tb/tb_video_pixel_fetch.sv
// Directed-vector bench for video_pixel_fetch: drives the timing position directly and models
// a framebuffer whose word at each address equals the low 16 address bits.
module tb_video_pixel_fetch;

  logic        clk_pix = 1'b0;
  logic        rst;
  logic [9:0]  sx, sy;
  logic        de, hsync, vsync;
  logic [19:0] fb_base;
  logic        pal_we;
  logic [3:0]  pal_addr;
  logic [11:0] pal_data;
  logic [11:0] rgb;
  logic        de_o, hsync_o, vsync_o, underrun;

  int n_vec = 0;
  int n_err = 0;
  int ack_period = 1;
  int ack_cnt = 0;

  video_pixel_fetch_if mem_bus ();

  video_pixel_fetch #(.FB_WORDS(80), .SRC_ROWS(240)) dut (
    .clk_pix (clk_pix),
    .rst     (rst),
    .sx      (sx),
    .sy      (sy),
    .de      (de),
    .hsync   (hsync),
    .vsync   (vsync),
    .fb_base (fb_base),
    .mem     (mem_bus),
    .pal_we  (pal_we),
    .pal_addr(pal_addr),
    .pal_data(pal_data),
    .rgb     (rgb),
    .de_o    (de_o),
    .hsync_o (hsync_o),
    .vsync_o (vsync_o),
    .underrun(underrun)
  );

  always #5 clk_pix = ~clk_pix;

  assign mem_bus.mem_ack   = mem_bus.mem_req && (ack_cnt >= ack_period - 1);
  assign mem_bus.mem_rdata = mem_bus.mem_addr[15:0];

  always @(posedge clk_pix) begin
    if (mem_bus.mem_req && !mem_bus.mem_ack) ack_cnt <= ack_cnt + 1;
    else ack_cnt <= 0;
  end

  // Hand-computed line-0 pixels: words 0x0123 then 0x0124, palette[i] = 0x111*i.
  logic [11:0] exp_line0 [16] = '{12'h000, 12'h000, 12'h111, 12'h111, 12'h222, 12'h222, 12'h333, 12'h333,
                                  12'h000, 12'h000, 12'h111, 12'h111, 12'h222, 12'h222, 12'h444, 12'h444};

  function automatic logic hs_pat(input int i);
    return !(i == 5 || i == 6);
  endfunction

  function automatic logic vs_pat(input int i);
    return (i != 9);
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst = 1'b1; sx = 10'd700; sy = 10'd0; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
    fb_base = 20'h0; pal_we = 1'b0; pal_addr = 4'h0; pal_data = 12'h0;
    #1;
    check_vec("rst_req", 32'(mem_bus.mem_req), 32'd0);
    check_vec("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
    check_vec("rst_rgb", 32'(rgb), 32'd0);
    check_vec("rst_de_o", 32'(de_o), 32'd0);
    check_vec("rst_hsync_o", 32'(hsync_o), 32'd1);
    check_vec("rst_vsync_o", 32'(vsync_o), 32'd1);
    check_vec("rst_underrun", 32'(underrun), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // Row-0 prefetch at the last blanking line, memory acking every cycle.
    fb_base = 20'h01000; sx = 10'd0; sy = 10'd523;
    step();
    sx = 10'd1;
    for (int i = 0; i < 80; i++) begin
      check_vec("fetch_req", 32'(mem_bus.mem_req), 32'd1);
      check_vec("fetch_addr", 32'(mem_bus.mem_addr), 32'h01000 + 32'(i));
      step();
    end
    check_vec("fetch_done_req", 32'(mem_bus.mem_req), 32'd0);

    for (int i = 0; i < 16; i++) begin
      pal_we = 1'b1; pal_addr = 4'(i); pal_data = 12'(32'h111 * i);
      step();
    end
    pal_we = 1'b0;

    // Refill buf0 so that word 0 reads 0x0123.
    fb_base = 20'h00123; sx = 10'd0; sy = 10'd523;
    step();
    sx = 10'd1;
    for (int i = 0; i < 81; i++) step();
    check_vec("refill_done_req", 32'(mem_bus.mem_req), 32'd0);

    for (int i = 0; i <= 18; i++) begin
      if (i < 16) begin
        sx = 10'(i); sy = 10'd0; de = 1'b1; hsync = hs_pat(i); vsync = vs_pat(i);
      end else begin
        sx = 10'(640 + i); de = 1'b0; hsync = 1'b1; vsync = 1'b1;
      end
      step();
      if (i >= 1) begin
        check_vec("pix_rgb", 32'(rgb), (i - 1 < 16) ? 32'(exp_line0[i-1]) : 32'd0);
        check_vec("pix_de_o", 32'(de_o), (i - 1 < 16) ? 32'd1 : 32'd0);
        check_vec("pix_hsync_o", 32'(hsync_o), (i - 1 < 16) ? 32'(hs_pat(i - 1)) : 32'd1);
        check_vec("pix_vsync_o", 32'(vsync_o), (i - 1 < 16) ? 32'(vs_pat(i - 1)) : 32'd1);
      end
    end

    // Word 2 = 0x0125: sx 22/23 use entry 5; write entry 5 on the edge that reads it.
    sx = 10'd22; sy = 10'd0; de = 1'b1;
    step();
    sx = 10'd23; pal_we = 1'b1; pal_addr = 4'd5; pal_data = 12'hF0F;
    step();
    check_vec("pal_old", 32'(rgb), 32'h555);
    pal_we = 1'b0; de = 1'b0; sx = 10'd700;
    step();
    check_vec("pal_new", 32'(rgb), 32'hF0F);
    check_vec("no_underrun", 32'(underrun), 32'd0);

    for (int i = 0; i < 90; i++) step();
    check_vec("idle_req", 32'(mem_bus.mem_req), 32'd0);
    for (int y = 478; y <= 522; y++) begin
      sx = 10'd0; sy = 10'(y);
      step();
      check_vec("no_trig_req", 32'(mem_bus.mem_req), 32'd0);
    end
    sx = 10'd1;

    // Slow memory: row-1 fetch still running when the sy=2 trigger arrives.
    ack_period = 30; fb_base = 20'h01000; sx = 10'd0; sy = 10'd0;
    step();
    sx = 10'd1;
    check_vec("slow_req", 32'(mem_bus.mem_req), 32'd1);
    check_vec("slow_addr", 32'(mem_bus.mem_addr), 32'h01050);
    for (int i = 0; i < 40; i++) step();
    check_vec("slow_busy", 32'(mem_bus.mem_req), 32'd1);
    check_vec("slow_no_underrun", 32'(underrun), 32'd0);
    sx = 10'd0; sy = 10'd2;
    step();
    sx = 10'd1;
    check_vec("restart_underrun", 32'(underrun), 32'd1);
    check_vec("restart_req", 32'(mem_bus.mem_req), 32'd1);
    check_vec("restart_addr", 32'(mem_bus.mem_addr), 32'h010A0);
    for (int j = 0; j <= 8; j++) begin
      if (j < 8) begin
        sy = (j < 4) ? 10'd2 : 10'd3; sx = 10'(8 + (j % 4)); de = 1'b1;
      end else begin
        de = 1'b0; sx = 10'd700;
      end
      step();
      if (j >= 1) begin
        check_vec("inval_rgb", 32'(rgb), 32'd0);
        check_vec("inval_de_o", 32'(de_o), 32'd1);
      end
    end

    // Reset in the middle of the row-2 fetch at word 40.
    ack_period = 1; sx = 10'd1;
    for (int k = 0; k < 300 && !(mem_bus.mem_req && mem_bus.mem_addr == 20'h010C8); k++) step();
    check_vec("word40_addr", 32'(mem_bus.mem_addr), 32'h010C8);
    rst = 1'b1;
    #1;
    check_vec("async_req", 32'(mem_bus.mem_req), 32'd0);
    check_vec("async_addr", 32'(mem_bus.mem_addr), 32'd0);
    check_vec("async_underrun", 32'(underrun), 32'd0);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sx = 10'(10 + k); sy = 10'd3;
      step();
      seen = seen | mem_bus.mem_req;
    end
    check_vec("post_rst_idle", 32'(seen), 32'd0);
    sx = 10'd0; sy = 10'd4;
    step();
    sx = 10'd1;
    check_vec("next_trig_req", 32'(mem_bus.mem_req), 32'd1);
    check_vec("next_trig_addr", 32'(mem_bus.mem_addr), 32'h010F0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_pixel_fetch.md
VIDEO_PIXEL_FETCH -- requirements
Module: video_pixel_fetch

Interface
REQ-001 SHALL have parameter FB_WORDS, default 80, meaning 16-bit words per source row (320 px, 4 bpp).
REQ-002 SHALL have parameter SRC_ROWS, default 240, meaning source rows per frame (each row shown on 2 output lines).
REQ-003 clk_pix  in  1  pixel clock; the block's single clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 sx, sy  in  10 each  screen position from the 640x480 timing generator (line 0..799, frame 0..524).
REQ-006 de, hsync, vsync  in  1 each  timing-generator data enable and negative-polarity syncs, aligned with sx/sy.
REQ-007 fb_base  in  20  framebuffer word base address.
REQ-008 mem_req  out  1  read request; mem_addr  out  20  word address; mem_ack  in  1  one-cycle accept; mem_rdata  in  16  read data, valid when mem_ack=1.
REQ-009 pal_we  in  1; pal_addr  in  4; pal_data  in  12  palette write port, RGB444.
REQ-010 rgb  out  12; de_o, hsync_o, vsync_o  out  1 each  pixel output and delayed timing.
REQ-011 underrun  out  1  sticky error flag.

Function
REQ-012 Two line buffers (buf0, buf1) of FB_WORDS x 16 bits SHALL be provided; source row k displays from buf[k&1] on output lines 2k and 2k+1.
REQ-013 Fetch triggers, evaluated when sx==0: sy==523 -> fetch row 0 into buf0; sy even and sy/2+1 < SRC_ROWS -> fetch row sy/2+1 into buf[(sy/2+1)&1]. No other trigger.
REQ-014 At trigger, fb_base SHALL be sampled; row address = fb_base + row*FB_WORDS (20-bit wrap-around); word counter cleared.
REQ-015 FSM states: IDLE, REQ. IDLE->REQ on trigger. REQ: mem_req=1, mem_addr=row address + counter, held stable until mem_ack.
REQ-016 On mem_ack in REQ: mem_rdata written to target buffer at counter; counter+1; if counter==FB_WORDS-1, -> IDLE with mem_req=0 the next cycle; else remain in REQ with next address the next cycle.
REQ-017 A trigger arriving while in REQ SHALL set underrun, abandon the current fetch, and restart at the new row.
REQ-018 Each buffer SHALL have a valid bit: cleared at fetch start for that buffer, set on the final ack.
REQ-019 Pixel path, stage 1: when de=1, read word sx[9:3] from buf[(sy>>1)&1] and register nibble select sx[2:1]; nibble 0 = bits 15:12, nibble 3 = bits 3:0.
REQ-020 Stage 2: rgb <= palette[selected nibble] if the stage-1 de was 1 and the buffer was valid; else rgb <= 0.
REQ-021 Reading an invalid buffer with de=1 SHALL set underrun; underrun SHALL clear only on rst.
REQ-022 de_o, hsync_o and vsync_o SHALL be de, hsync and vsync delayed exactly 2 cycles; total latency sx->rgb = 2 cycles.
REQ-023 Palette SHALL be 16 x 12 registers, written on pal_we at clk_pix edge; a write and a read of the same entry in the same cycle SHALL return the old value.
REQ-024 rgb SHALL be 0 whenever de_o=0.

Reset
REQ-025 While rst=1: FSM=IDLE, mem_req=0, mem_addr=0, counter=0, both valid bits=0, palette entries=0, rgb=0, de_o=0, hsync_o=1, vsync_o=1, underrun=0; all asynchronously.
REQ-026 Deassertion of rst mid-fetch SHALL leave the block in IDLE until the next trigger; no partial fetch resumes.

Verification
REQ-027 fb_base=0x01000, memory acks every cycle, memory word = address[15:0]: sy=523,sx=0 -> 80 requests at 0x01000..0x0104F, mem_req low after the 80th ack, buf0 valid.
REQ-028 Palette i = 0x111*i, row-0 word0=0x0123: line 0, sx=0..7 -> rgb at sx+2 = 000,000,111,111,222,222,333,333; de_o/hsync_o track inputs delayed by 2.
REQ-029 Memory acks every 30th cycle (80 words take 2400 cycles): trigger at sy=0 is still fetching at sy=2 -> underrun=1, fetch restarts for row 2; rgb=0 on lines 2-3.
REQ-030 No trigger at sy=478 (row 240 >= SRC_ROWS): mem_req stays 0 through lines 478-522.
REQ-031 Assert rst with mem_req=1 at word 40 -> mem_req=0 with no clock edge; after release, no request until sy=523,sx=0 or an even-line trigger.
REQ-032 pal_we to entry 5 with data 0xF0F on the same cycle stage 2 reads entry 5 -> rgb shows the old value; the next read of entry 5 shows 0xF0F.
